// File: rtl/mem_burst_reader.sv
// Burst reader over a single-port-write memory: accepts (addr, len) commands and
// streams len+1 consecutive words, one word every two cycles, with valid/ready output.
module mem_burst_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;

  // NOTE: the memory array has no reset; clearing it would turn the RAM into
  // flops, and its contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking assignments here mean the FETCH read of mem[ptr] sees the
  // pre-edge contents, so a same-cycle write to that address returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
            state     <= FETCH;
          end
        end
        FETCH: begin
          out_data <= mem[ptr];
          out_last <= (remaining == '0);
          state    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state <= IDLE;
            end else begin
              ptr       <= ptr + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);

endmodule
